uart_bus_master: RTL and testbench

UART-driven bus initiator that turns byte commands from the UART receiver into single `rd`/`wr` transactions on the peripheral bus. It returns an acknowledge byte or the read data through the UART sender. It sits between the `receive`/`sender` UART pair and the 0x4000_00xx peripheral address space, and is muxed with the CPU bus by the top level. It gives a host PC debug access to timers, LEDs, switches, digits and UART registers without CPU involvement.

---
 rtl/uart_bus_master.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// uart_bus_master: turns byte commands from the UART receiver into single
// rd/wr transactions on the peripheral bus and answers through the UART
// sender. 'W' A3..A0 D3..D0 writes a word and answers 'K'; 'R' A3..A0
// reads a word and answers with its four bytes MSB first; any other
// opening byte is answered with '?'.
module uart_bus_master #(
    parameter logic [31:0] TIMEOUT = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        overrun
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_TX_LOAD,
        S_TX_WAIT_HI,
        S_TX_WAIT_LO
    } state_t;

    state_t      state_q;
    logic        is_wr_q;     // latched opcode: 1 = write, 0 = read
    logic [1:0]  cnt_q;       // byte index inside the current 4-byte field
    logic [31:0] tmo_q;       // inter-byte timeout counter
    logic [31:0] addr_sh_q;
    logic [31:0] wdata_sh_q;
    logic [31:0] tx_sh_q;     // response bytes, next to send in [31:24]
    logic [1:0]  remain_q;    // response bytes still to send after the current one
    logic        tx_en_q;
    logic [7:0]  tx_data_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        overrun_q;

    // Shift registers with the incoming byte appended; used both to update
    // the field and to drive the bus directly on the last byte.
    logic [31:0] addr_sh_d;
    logic [31:0] wdata_sh_d;
    logic        rx_blocked;

    assign addr_sh_d  = {addr_sh_q[23:0], rx_data};
    assign wdata_sh_d = {wdata_sh_q[23:0], rx_data};
    assign rx_blocked = (state_q == S_BUS) || (state_q == S_TX_LOAD) ||
                        (state_q == S_TX_WAIT_HI) || (state_q == S_TX_WAIT_LO);

    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign rd      = rd_q;
    assign wr      = wr_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

    // Command FSM with registered bus strobes, sender handshake and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            cnt_q      <= 2'd0;
            tmo_q      <= 32'd0;
            addr_sh_q  <= 32'd0;
            wdata_sh_q <= 32'd0;
            tx_sh_q    <= 32'd0;
            remain_q   <= 2'd0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // NOTE: strobes default low here so every path that does not
            // explicitly raise them yields a clean one-cycle pulse; all
            // state uses non-blocking assignment so each branch reads the
            // pre-edge values.
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            tx_en_q <= 1'b0;

            if (rx_valid && rx_blocked) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        busy_q <= 1'b1;
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            is_wr_q <= (rx_data == OP_WRITE);
                            cnt_q   <= 2'd0;
                            tmo_q   <= 32'd0;
                            state_q <= S_ADDR;
                        end else begin
                            tx_sh_q   <= {RSP_BAD, 24'd0};
                            remain_q  <= 2'd0;
                            tx_data_q <= RSP_BAD;
                            tx_en_q   <= !tx_busy;
                            state_q   <= S_TX_LOAD;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_valid) begin
                        addr_sh_q <= addr_sh_d;
                        cnt_q     <= cnt_q + 2'd1;
                        tmo_q     <= 32'd0;
                        if (cnt_q == 2'd3) begin
                            if (is_wr_q) begin
                                state_q <= S_DATA;
                            end else begin
                                addr_q  <= addr_sh_d;
                                rd_q    <= 1'b1;
                                state_q <= S_BUS;
                            end
                        end
                    end else if (tmo_q >= TIMEOUT) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        wdata_sh_q <= wdata_sh_d;
                        cnt_q      <= cnt_q + 2'd1;
                        tmo_q      <= 32'd0;
                        if (cnt_q == 2'd3) begin
                            addr_q  <= addr_sh_q;
                            wdata_q <= wdata_sh_d;
                            wr_q    <= 1'b1;
                            state_q <= S_BUS;
                        end
                    end else if (tmo_q >= TIMEOUT) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end

                // The strobe is visible during this cycle; the first
                // response byte is issued on entry to TX_LOAD if the sender
                // is free, so tx_en follows BUS by exactly one cycle.
                S_BUS: begin
                    if (is_wr_q) begin
                        tx_sh_q   <= {RSP_ACK, 24'd0};
                        remain_q  <= 2'd0;
                        tx_data_q <= RSP_ACK;
                    end else begin
                        tx_sh_q   <= rdata;
                        remain_q  <= 2'd3;
                        tx_data_q <= rdata[31:24];
                    end
                    tx_en_q <= !tx_busy;
                    state_q <= S_TX_LOAD;
                end

                S_TX_LOAD: begin
                    if (tx_en_q) begin
                        state_q <= S_TX_WAIT_HI;
                    end else if (!tx_busy) begin
                        tx_data_q <= tx_sh_q[31:24];
                        tx_en_q   <= 1'b1;
                    end
                end

                S_TX_WAIT_HI: begin
                    if (tx_busy) begin
                        state_q <= S_TX_WAIT_LO;
                    end
                end

                S_TX_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (remain_q != 2'd0) begin
                            tx_sh_q   <= {tx_sh_q[23:0], 8'd0};
                            remain_q  <= remain_q - 2'd1;
                            tx_data_q <= tx_sh_q[23:16];
                            tx_en_q   <= 1'b1;
                            state_q   <= S_TX_LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master: directed commands, a transaction-level
// model (expected bus operations and response bytes in queues) and one
// monitor that checks every strobe and every tx_en against the model.
module tb_uart_bus_master;

    localparam logic [31:0] TMO = 32'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        overrun;

    logic [31:0] rdata_val = 32'd0;
    int          busy_len = 4;

    // Peripheral answers only while rd is high, otherwise garbage.
    assign rdata = rd ? rdata_val : 32'hDEAD_BEEF;

    uart_bus_master #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .overrun  (overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_op_t;

    bus_op_t    exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] obs_tx[$];
    int         tx_count = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // UART sender model: busy for busy_len cycles after each start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1 && reset === 1'b1) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: compares every strobe and start pulse against the model.
    initial begin
        logic       prev_tx_en = 1'b0;
        logic       prev_rdwr  = 1'b0;
        logic       busy_seen  = 1'b1;
        logic       hold_valid = 1'b0;
        logic [7:0] hold_byte  = 8'd0;
        bus_op_t    op;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1) begin
                prev_tx_en = 1'b0;
                prev_rdwr  = 1'b0;
                busy_seen  = 1'b1;
                hold_valid = 1'b0;
            end else begin
                if (rd || wr) begin
                    check("rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
                    check("strobe_one_cycle", {31'd0, prev_rdwr}, 32'd0);
                    check("bus_op_expected", exp_bus.size(), (exp_bus.size() == 0) ? 32'd1 : exp_bus.size());
                    if (exp_bus.size() != 0) begin
                        op = exp_bus.pop_front();
                        check("bus_kind_wr", {31'd0, wr}, {31'd0, op.is_wr});
                        check("bus_addr", addr, op.addr);
                        if (op.is_wr) check("bus_wdata", wdata, op.wdata);
                    end
                end
                if (hold_valid && tx_busy) check("tx_data_held", {24'd0, tx_data}, {24'd0, hold_byte});
                if (!tx_busy) hold_valid = 1'b0;
                if (tx_en) begin
                    check("tx_en_while_busy", {31'd0, tx_busy}, 32'd0);
                    check("tx_en_one_cycle", {31'd0, prev_tx_en}, 32'd0);
                    check("tx_en_after_busy_period", {31'd0, busy_seen}, 32'd1);
                    check("tx_byte_expected", exp_tx.size(), (exp_tx.size() == 0) ? 32'd1 : exp_tx.size());
                    if (exp_tx.size() != 0) check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                    obs_tx.push_back(tx_data);
                    tx_count++;
                    busy_seen  = 1'b0;
                    hold_valid = 1'b1;
                    hold_byte  = tx_data;
                end
                if (tx_busy) busy_seen = 1'b1;
                prev_tx_en = tx_en;
                prev_rdwr  = rd | wr;
            end
        end
    end

    // One byte from the receiver; called at a negedge, returns one cycle later.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(8'((w >> (8 * i)) & 32'hFF));
    endtask

    task automatic run_write(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back('{is_wr: 1'b1, addr: a, wdata: d});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        check("busy_after_opcode", {31'd0, busy}, 32'd1);
        send_word(a);
        for (int i = 3; i >= 1; i--) send_byte(8'((d >> (8 * i)) & 32'hFF));
        send_byte(8'(d & 32'hFF));
        check("wr_latency", {30'd0, rd, wr}, 32'd1);
    endtask

    // gap: idle cycles inserted before the last address byte.
    task automatic run_read(input logic [31:0] a, input logic [31:0] v, input int gap);
        rdata_val = v;
        exp_bus.push_back('{is_wr: 1'b0, addr: a, wdata: 32'd0});
        for (int i = 3; i >= 0; i--) exp_tx.push_back(8'((v >> (8 * i)) & 32'hFF));
        send_byte(8'h52);
        check("busy_after_opcode", {31'd0, busy}, 32'd1);
        for (int i = 3; i >= 1; i--) send_byte(8'((a >> (8 * i)) & 32'hFF));
        repeat (gap) @(negedge clk);
        send_byte(8'(a & 32'hFF));
        check("rd_latency", {30'd0, rd, wr}, 32'd2);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        check({name, "_all_sent"}, exp_tx.size(), 32'd0);
        check({name, "_all_bus"}, exp_bus.size(), 32'd0);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_count_reached", tx_count, target);
    endtask

    // Hard stop in case a handshake never completes.
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int base;
        #1;
        check("reset_tx_en", {31'd0, tx_en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_addr", addr, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Write 0x000000A5 to 0x4000000C, answered with 'K'.
        run_write(32'h4000_000C, 32'h0000_00A5);
        wait_idle("write_done", 200);
        check("write_addr_held", addr, 32'h4000_000C);
        check("write_wdata_held", wdata, 32'h0000_00A5);
        check("write_rsp_lit", {24'd0, obs_tx[obs_tx.size() - 1]}, 32'h4B);

        // Read 0x40000010 returning 0x12: bytes 00 00 00 12.
        base = obs_tx.size();
        run_read(32'h4000_0010, 32'h0000_0012, 0);
        wait_idle("read_done", 400);
        check("read_rsp_lit0", {24'd0, obs_tx[base]}, 32'h00);
        check("read_rsp_lit3", {24'd0, obs_tx[base + 3]}, 32'h12);
        check("read_rsp_count", obs_tx.size() - base, 32'd4);

        // Unknown opcode answered with '?', no bus cycle.
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle("unknown_done", 200);
        check("unknown_rsp_lit", {24'd0, obs_tx[obs_tx.size() - 1]}, 32'h3F);

        // Partial write abandoned by the inter-byte timeout.
        base = tx_count;
        send_byte(8'h57);
        send_byte(8'h40);
        send_byte(8'h00);
        repeat (101) @(negedge clk);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        check("timeout_no_tx", tx_count, base);
        check("timeout_no_overrun", {31'd0, overrun}, 32'd0);

        // Read with a 99-cycle pause before the last byte: still accepted.
        run_read(32'h4000_0014, 32'h5752_A55A, 99);
        wait_idle("late_byte_read_done", 400);

        // Overrun while the response is held up by a long busy period.
        busy_len = 50;
        base = tx_count;
        run_read(32'h4000_0004, 32'hA1B2_C3D4, 0);
        wait_tx(base + 1, 50);
        send_byte(8'h52);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_idle("overrun_read_done", 1000);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        check("overrun_rsp_byte1", {24'd0, obs_tx[obs_tx.size() - 3]}, 32'hB2);
        busy_len = 4;

        // Reset after the second response byte of a read.
        base = tx_count;
        run_read(32'h4000_0018, 32'h1234_5678, 0);
        wait_tx(base + 2, 100);
        reset = 1'b0;
        #1;
        check("rst_tx_en", {31'd0, tx_en}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_rd_wr", {30'd0, rd, wr}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        exp_tx.delete();
        exp_bus.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_no_more_tx", tx_count, base + 2);

        run_write(32'h4000_0008, 32'hCAFE_0001);
        wait_idle("post_reset_write_done", 200);
        check("post_reset_overrun", {31'd0, overrun}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
